// File: rtl/network_sink.sv
// network_sink: output-side dispatcher and packet encoder.
// Captures the network output spike vector once per completed timestep and
// serializes it as SPK packets (lowest index first) closed by a CYC packet.
// Optional feature macro: SINK_RLE_EN (run-length coalescing of empty timesteps).
// Packet layout: snk[SNK_WIDTH-1] = opcode (0 = SPK, 1 = CYC), payload in low bits.
module network_sink #(
  parameter int NET_NUM_OUT = 4,
  parameter int CYC_WIDTH   = 8,
  parameter int IDX_W       = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1,
  parameter int SNK_WIDTH   = 1 + ((IDX_W > CYC_WIDTH) ? IDX_W : CYC_WIDTH)
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   net_valid,
  output logic                   net_ready,
  input  logic [NET_NUM_OUT-1:0] net_out,
  input  logic                   flush,
  output logic                   snk_valid,
  input  logic                   snk_ready,
  output logic [SNK_WIDTH-1:0]   snk
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRE_CYC = 2'd1,
    SPK     = 2'd2,
    CYC     = 2'd3
  } state_t;

  localparam logic [CYC_WIDTH-1:0] CYC_ONE = CYC_WIDTH'(1);
`ifdef SINK_RLE_EN
  localparam logic [CYC_WIDTH-1:0] CYC_MAX = '1;
`endif

  state_t                 state;
  logic [NET_NUM_OUT-1:0] pv;
  logic [NET_NUM_OUT-1:0] pv_clr;
`ifdef SINK_RLE_EN
  logic [CYC_WIDTH-1:0]   ec;
  logic [CYC_WIDTH-1:0]   ec_inc;
`else
  logic                   unused_flush;
`endif

  // Index of the lowest set bit; spikes go out in ascending index order.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NET_NUM_OUT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NET_NUM_OUT - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [SNK_WIDTH-1:0] spk_pkt(input logic [IDX_W-1:0] idx);
    logic [SNK_WIDTH-1:0] p;
    p = '0;
    p[IDX_W-1:0] = idx;
    return p;
  endfunction

  function automatic logic [SNK_WIDTH-1:0] cyc_pkt(input logic [CYC_WIDTH-1:0] count);
    logic [SNK_WIDTH-1:0] p;
    p = '0;
    p[SNK_WIDTH-1]   = 1'b1;
    p[CYC_WIDTH-1:0] = count;
    return p;
  endfunction

  // Pending vector with its lowest set bit (the spike being sent) removed.
  assign pv_clr    = pv & (pv - 1'b1);
  assign net_ready = (state == IDLE);

`ifdef SINK_RLE_EN
  assign ec_inc = ec + 1'b1;
`else
  assign unused_flush = flush;
`endif

  // Main FSM: packet and valid are registered so they hold under back-pressure.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      pv        <= '0;
      snk       <= '0;
      snk_valid <= 1'b0;
`ifdef SINK_RLE_EN
      ec        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (net_valid) begin
            pv <= net_out;
            if (net_out != '0) begin
              snk_valid <= 1'b1;
`ifdef SINK_RLE_EN
              if (ec != '0) begin
                state <= PRE_CYC;
                snk   <= cyc_pkt(ec);
              end else
`endif
              begin
                state <= SPK;
                snk   <= spk_pkt(lowest_idx(net_out));
              end
            end else begin
`ifdef SINK_RLE_EN
              ec <= ec_inc;
              if (ec_inc == CYC_MAX) begin
                state     <= CYC;
                snk       <= cyc_pkt(ec_inc);
                snk_valid <= 1'b1;
              end
`else
              state     <= CYC;
              snk       <= cyc_pkt(CYC_ONE);
              snk_valid <= 1'b1;
`endif
            end
          end
`ifdef SINK_RLE_EN
          else if (flush && ec != '0) begin
            state     <= CYC;
            snk       <= cyc_pkt(ec);
            snk_valid <= 1'b1;
          end
`endif
        end
        PRE_CYC: begin
          if (snk_ready) begin
`ifdef SINK_RLE_EN
            ec <= '0;
`endif
            state <= SPK;
            snk   <= spk_pkt(lowest_idx(pv));
          end
        end
        SPK: begin
          if (snk_ready) begin
            pv <= pv_clr;
            if (pv_clr == '0) begin
              state <= CYC;
              snk   <= cyc_pkt(CYC_ONE);
            end else begin
              snk <= spk_pkt(lowest_idx(pv_clr));
            end
          end
        end
        CYC: begin
          if (snk_ready) begin
`ifdef SINK_RLE_EN
            ec <= '0;
`endif
            state     <= IDLE;
            snk       <= '0;
            snk_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          snk       <= '0;
          snk_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_network_sink.sv
// tb_network_sink: directed self-checking bench for network_sink
// (NET_NUM_OUT = 4, CYC_WIDTH = 4, packet width 5). RLE steps run only
// when SINK_RLE_EN is defined.
module tb_network_sink;

  logic       clk;
  logic       arstn;
  logic       net_valid;
  logic       net_ready;
  logic [3:0] net_out;
  logic       flush;
  logic       snk_valid;
  logic       snk_ready;
  logic [4:0] snk;

  int checks;
  int failures;

  network_sink #(
    .NET_NUM_OUT(4),
    .CYC_WIDTH  (4),
    .IDX_W      (2),
    .SNK_WIDTH  (5)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .net_valid(net_valid),
    .net_ready(net_ready),
    .net_out  (net_out),
    .flush    (flush),
    .snk_valid(snk_valid),
    .snk_ready(snk_ready),
    .snk      (snk)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic nv, input logic [3:0] no,
                               input logic sr, input logic fl);
    net_valid = nv;
    net_out   = no;
    snk_ready = sr;
    flush     = fl;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev,
                             input logic [4:0] es, input logic er);
    checks++;
    assert (snk_valid === ev) else begin
      failures++;
      $error("[TB] FAIL %s snk_valid observed=%0b expected=%0b", tag, snk_valid, ev);
    end
    checks++;
    assert (snk === es) else begin
      failures++;
      $error("[TB] FAIL %s snk observed=%b expected=%b", tag, snk, es);
    end
    checks++;
    assert (net_ready === er) else begin
      failures++;
      $error("[TB] FAIL %s net_ready observed=%0b expected=%0b", tag, net_ready, er);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    arstn    = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    #12;
    checkOutput("reset", 1'b0, 5'b00000, 1'b1);
    arstn = 1'b1;
    tick();
    checkOutput("post_reset_idle", 1'b0, 5'b00000, 1'b1);

`ifndef SINK_RLE_EN
    // 1010 with continuous ready: SPK(1), SPK(3), CYC(1), then idle at T+4.
    applyStimulus(1'b1, 4'b1010, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b1010, 1'b1, 1'b0);
    checkOutput("a_spk1", 1'b1, 5'b00001, 1'b0);
    tick();
    checkOutput("a_spk3", 1'b1, 5'b00011, 1'b0);
    tick();
    checkOutput("a_cyc1", 1'b1, 5'b10001, 1'b0);
    tick();
    checkOutput("a_idle", 1'b0, 5'b00000, 1'b1);

    // Back-pressure: SPK(0) held stable for three cycles.
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_spk0", 1'b1, 5'b00000, 1'b0);
      if (i < 2) tick();
    end
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    tick();
    checkOutput("bp_cyc1", 1'b1, 5'b10001, 1'b0);
    tick();
    checkOutput("bp_idle", 1'b0, 5'b00000, 1'b1);

    // Three empty timesteps: one CYC(1) each, no SPK.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
      checkOutput("empty_cyc1", 1'b1, 5'b10001, 1'b0);
      tick();
      checkOutput("empty_idle", 1'b0, 5'b00000, 1'b1);
    end

    // Flush has no effect without RLE.
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    checkOutput("flush_ignored", 1'b0, 5'b00000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
`else
    // RLE: two empty timesteps then 0100 -> CYC(2), SPK(2), CYC(1).
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("rle_empty1", 1'b0, 5'b00000, 1'b1);
    tick();
    checkOutput("rle_empty2", 1'b0, 5'b00000, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    checkOutput("rle_precyc2", 1'b1, 5'b10010, 1'b0);
    tick();
    checkOutput("rle_spk2", 1'b1, 5'b00010, 1'b0);
    tick();
    checkOutput("rle_cyc1", 1'b1, 5'b10001, 1'b0);
    tick();
    checkOutput("rle_idle", 1'b0, 5'b00000, 1'b1);

    // 15 empty timesteps saturate into a single CYC(15).
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("rle_sat_pending", 1'b0, 5'b00000, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("rle_cyc15", 1'b1, 5'b11111, 1'b0);
    tick();
    checkOutput("rle_sat_idle", 1'b0, 5'b00000, 1'b1);

    // Three empty timesteps then flush -> CYC(3).
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput("rle_flush_cyc3", 1'b1, 5'b10011, 1'b0);
    tick();
    checkOutput("rle_flush_idle", 1'b0, 5'b00000, 1'b1);
`endif

    // Reset mid-SPK after one of three spikes was accepted.
    applyStimulus(1'b1, 4'b0111, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0111, 1'b1, 1'b0);
    checkOutput("rst_spk0", 1'b1, 5'b00000, 1'b0);
    tick();
    checkOutput("rst_spk1", 1'b1, 5'b00001, 1'b0);
    arstn = 1'b0;
    #1;
    checkOutput("rst_async", 1'b0, 5'b00000, 1'b1);
    #3;
    arstn = 1'b1;
    tick();
    checkOutput("rst_released", 1'b0, 5'b00000, 1'b1);
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b0);
    checkOutput("rst_after_spk0", 1'b1, 5'b00000, 1'b0);
    tick();
    checkOutput("rst_after_cyc1", 1'b1, 5'b10001, 1'b0);
    tick();
    checkOutput("rst_after_idle", 1'b0, 5'b00000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
